regfile_scoreboard: RTL



---
 rtl/regfile_scoreboard_if.sv | 39 +++
 rtl/regfile_scoreboard.sv | 101 ++++++++++
 2 files changed

// File: rtl/regfile_scoreboard_if.sv
// Write-back, read-port and issue/scoreboard signals between the pipeline and regfile_scoreboard.
interface regfile_scoreboard_if;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 3;

    logic [DATA_W-1:0] wb_result;
    logic [ADDR_W-1:0] wb_dest_addr;
    logic              wb_we;
    logic [ADDR_W-1:0] rd_addr_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [DATA_W-1:0] rd_data_a;
    logic [DATA_W-1:0] rd_data_b;
    logic              issue_valid;
    logic              issue_we;
    logic [ADDR_W-1:0] issue_dest_addr;
    logic              src_a_used;
    logic              src_b_used;
    logic              flush;
    logic              stall;
    logic              sb_underflow;

    // Pipeline side: drives write-back and issue, observes reads and stall.
    modport master (
        output wb_result, wb_dest_addr, wb_we,
        output rd_addr_a, rd_addr_b,
        output issue_valid, issue_we, issue_dest_addr,
        output src_a_used, src_b_used, flush,
        input  rd_data_a, rd_data_b, stall, sb_underflow
    );

    // Register file side.
    modport slave (
        input  wb_result, wb_dest_addr, wb_we,
        input  rd_addr_a, rd_addr_b,
        input  issue_valid, issue_we, issue_dest_addr,
        input  src_a_used, src_b_used, flush,
        output rd_data_a, rd_data_b, stall, sb_underflow
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Eight-entry 16-bit register file with per-register pending-write counters
// that stall issue while an operand or destination is still in flight.
// Optional feature: define REGFILE_BYPASS_EN to forward the write-back value
// to the read ports and let a retiring last write release a waiting source.
module regfile_scoreboard #(
    parameter int unsigned PEND_W = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    regfile_scoreboard_if.slave  bus
);
    localparam int unsigned NREG   = 8;
    localparam int unsigned DATA_W = 16;
    localparam logic [PEND_W-1:0] PEND_MAX = '1;
    localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

    logic [DATA_W-1:0] regs [NREG];
    logic [PEND_W-1:0] pend [NREG];
    logic              sb_underflow_q;

    logic [DATA_W-1:0] rd_data_a_c;
    logic [DATA_W-1:0] rd_data_b_c;
    logic              byp_a_c;
    logic              byp_b_c;
    logic              src_a_ok_c;
    logic              src_b_ok_c;
    logic              dest_full_c;
    logic              stall_c;
    logic              inc_c;
    logic              dec_c;
    logic              same_c;

    // Read ports, with optional write-back forwarding and bypass-release of sources.
    always_comb begin
        rd_data_a_c = regs[bus.rd_addr_a];
        rd_data_b_c = regs[bus.rd_addr_b];
        byp_a_c     = 1'b0;
        byp_b_c     = 1'b0;
`ifdef REGFILE_BYPASS_EN
        if (bus.wb_we && (bus.rd_addr_a == bus.wb_dest_addr)) begin
            rd_data_a_c = bus.wb_result;
        end
        if (bus.wb_we && (bus.rd_addr_b == bus.wb_dest_addr)) begin
            rd_data_b_c = bus.wb_result;
        end
        byp_a_c = (pend[bus.rd_addr_a] == PEND_ONE) && bus.wb_we
                  && (bus.wb_dest_addr == bus.rd_addr_a);
        byp_b_c = (pend[bus.rd_addr_b] == PEND_ONE) && bus.wb_we
                  && (bus.wb_dest_addr == bus.rd_addr_b);
`endif
    end

    // Operand readiness, destination saturation and the resulting stall.
    always_comb begin
        src_a_ok_c  = !bus.src_a_used || (pend[bus.rd_addr_a] == '0) || byp_a_c;
        src_b_ok_c  = !bus.src_b_used || (pend[bus.rd_addr_b] == '0) || byp_b_c;
        dest_full_c = bus.issue_we && (pend[bus.issue_dest_addr] == PEND_MAX)
                      && !(bus.wb_we && (bus.wb_dest_addr == bus.issue_dest_addr));
        stall_c     = bus.issue_valid && (!src_a_ok_c || !src_b_ok_c || dest_full_c);
        inc_c       = bus.issue_valid && !stall_c && bus.issue_we;
        dec_c       = bus.wb_we;
        same_c      = (bus.issue_dest_addr == bus.wb_dest_addr);
    end

    // Register storage, pending counters and sticky underflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
                pend[i] <= '0;
            end
            sb_underflow_q <= 1'b0;
        end else begin
            if (bus.wb_we) begin
                regs[bus.wb_dest_addr] <= bus.wb_result;
            end
            if (bus.flush) begin
                for (int i = 0; i < NREG; i++) begin
                    pend[i] <= '0;
                end
            end else begin
                // Matching inc and dec on one register cancel out.
                if (inc_c && !(dec_c && same_c)) begin
                    pend[bus.issue_dest_addr] <= pend[bus.issue_dest_addr] + PEND_ONE;
                end
                if (dec_c && !(inc_c && same_c)) begin
                    if (pend[bus.wb_dest_addr] == '0) begin
                        sb_underflow_q <= 1'b1;
                    end else begin
                        pend[bus.wb_dest_addr] <= pend[bus.wb_dest_addr] - PEND_ONE;
                    end
                end
            end
        end
    end

    assign bus.rd_data_a    = rd_data_a_c;
    assign bus.rd_data_b    = rd_data_b_c;
    assign bus.stall        = stall_c;
    assign bus.sb_underflow = sb_underflow_q;
endmodule
